// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes (common with the transmitter),
// receiver states and frame-format constants.
package uart_pkg;

    localparam logic [1:0] PARITY_SPACE = 2'b00;
    localparam logic [1:0] PARITY_ODD   = 2'b01;
    localparam logic [1:0] PARITY_EVEN  = 2'b10;
    localparam logic [1:0] PARITY_MARK  = 2'b11;

    // dataBits input encodes the data-bit count relative to this base.
    localparam int DATA_BITS_BASE = 5;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP1,
        RX_STOP2
    } rxState_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial rx pin plus falling-edge detection
// on the synchronised line; every flop resets to the idle level 1.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rxs,
    output logic startEdge
);

    logic rxMeta;
    logic rxsPrev;

    // NOTE: resetting all three flops high keeps reset release from
    // looking like a start edge; the line only counts after it returns high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta  <= 1'b1;
            rxs     <= 1'b1;
            rxsPrev <= 1'b1;
        end else begin
            rxMeta  <= rx;
            rxs     <= rxMeta;
            rxsPrev <= rxs;
        end
    end

    assign startEdge = rxsPrev & ~rxs;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: mid-bit sampling of a synchronised rx line, parity and stop
// checking, and a valid/ack holding register for the received word.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_DIVISOR_WIDTH = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rx,
    input  logic [1:0]                     dataBits,
    input  logic                           hasParity,
    input  logic [1:0]                     parityMode,
    input  logic                           extraStopBit,
    input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
    output logic [7:0]                     dataOut,
    output logic                           dataValid,
    output logic                           parityError,
    output logic                           framingError,
    output logic                           overrun,
    input  logic                           readData
);

    logic rxs;
    logic startEdge;

    uart_rx_sync rxSync (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rxs       (rxs),
        .startEdge (startEdge)
    );

    rxState_t                       state;
    logic [CLOCK_DIVISOR_WIDTH-1:0] latchedDiv;
    logic [CLOCK_DIVISOR_WIDTH-1:0] counter;
    logic [1:0]                     latchedBits;
    logic [1:0]                     latchedParityMode;
    logic                           latchedHasParity;
    logic                           latchedExtraStop;
    logic [2:0]                     bitCount;
    logic [7:0]                     shiftReg;
    logic                           pendParity;
    logic                           pendFrame;

    logic strobe;
    logic expectedParity;
    logic frameDone;

    always_comb begin
        strobe    = (counter == (latchedDiv >> 1));
        frameDone = strobe && (((state == RX_STOP1) && !latchedExtraStop) || (state == RX_STOP2));
        // Unreceived upper bits of shiftReg are zero, so a full-width XOR is exact.
        case (latchedParityMode)
            PARITY_EVEN: expectedParity = ^shiftReg;
            PARITY_ODD:  expectedParity = ~^shiftReg;
            PARITY_MARK: expectedParity = 1'b1;
            default:     expectedParity = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= RX_IDLE;
            counter           <= '0;
            latchedDiv        <= '0;
            latchedBits       <= '0;
            latchedParityMode <= PARITY_SPACE;
            latchedHasParity  <= 1'b0;
            latchedExtraStop  <= 1'b0;
            bitCount          <= '0;
            shiftReg          <= '0;
            pendParity        <= 1'b0;
            pendFrame         <= 1'b0;
            dataOut           <= '0;
            dataValid         <= 1'b0;
            parityError       <= 1'b0;
            framingError      <= 1'b0;
            overrun           <= 1'b0;
        end else begin
            if (state != RX_IDLE)
                counter <= (counter == latchedDiv) ? '0 : counter + 1'b1;

            case (state)
                RX_IDLE: begin
                    if (startEdge) begin
                        latchedDiv        <= clockDivisor;
                        latchedBits       <= dataBits;
                        latchedParityMode <= parityMode;
                        latchedHasParity  <= hasParity;
                        latchedExtraStop  <= extraStopBit;
                        counter           <= '0;
                        bitCount          <= '0;
                        shiftReg          <= '0;
                        pendParity        <= 1'b0;
                        pendFrame         <= 1'b0;
                        state             <= RX_START;
                    end
                end
                RX_START: begin
                    if (strobe)
                        state <= rxs ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    if (strobe) begin
                        shiftReg[bitCount] <= rxs;
                        bitCount           <= bitCount + 1'b1;
                        if (bitCount == 3'(DATA_BITS_BASE - 1) + {1'b0, latchedBits})
                            state <= latchedHasParity ? RX_PARITY : RX_STOP1;
                    end
                end
                RX_PARITY: begin
                    if (strobe) begin
                        pendParity <= (rxs != expectedParity);
                        state      <= RX_STOP1;
                    end
                end
                RX_STOP1: begin
                    if (strobe) begin
                        if (!rxs)
                            pendFrame <= 1'b1;
                        state <= latchedExtraStop ? RX_STOP2 : RX_IDLE;
                    end
                end
                RX_STOP2: begin
                    if (strobe)
                        state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase

            // A completing frame takes priority over an acknowledge in the same cycle.
            if (frameDone) begin
                dataOut      <= shiftReg;
                parityError  <= pendParity;
                framingError <= pendFrame | ~rxs;
                overrun      <= dataValid & ~readData;
                dataValid    <= 1'b1;
            end else if (readData && dataValid) begin
                dataValid    <= 1'b0;
                parityError  <= 1'b0;
                framingError <= 1'b0;
                overrun      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames are driven cycle by cycle and the
// expected held word/flags are queued at send time and checked on receipt.
module tb_uart_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        readData = 1'b0;
    logic [1:0]  dataBits = 2'd3;
    logic        hasParity = 1'b0;
    logic [1:0]  parityMode = 2'b00;
    logic        extraStopBit = 1'b0;
    logic [23:0] clockDivisor = 24'd9;
    logic [7:0]  dataOut;
    logic        dataValid;
    logic        parityError;
    logic        framingError;
    logic        overrun;

    uart_receiver #(.CLOCK_DIVISOR_WIDTH(24)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .dataBits     (dataBits),
        .hasParity    (hasParity),
        .parityMode   (parityMode),
        .extraStopBit (extraStopBit),
        .clockDivisor (clockDivisor),
        .dataOut      (dataOut),
        .dataValid    (dataValid),
        .parityError  (parityError),
        .framingError (framingError),
        .overrun      (overrun),
        .readData     (readData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Records the posedge count at which dataValid was first seen high.
    int   riseCyc = -1;
    logic prevValid = 1'b0;
    always @(negedge clk) begin
        if (dataValid === 1'b1 && prevValid !== 1'b1)
            riseCyc = cyc;
        prevValid = dataValid;
    end

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;
    int   lastStart = 0;
    int   cfgDiv = 9;
    int   cfgBits = 8;
    logic cfgPar = 1'b0;
    int   cfgStops = 1;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic parityFor(input logic [7:0] d, input int n, input logic [1:0] mode);
        logic x;
        x = 1'b0;
        for (int k = 0; k < n; k++) x ^= d[k];
        case (mode)
            2'b10:   return x;
            2'b01:   return ~x;
            2'b11:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic setCfg(input int div, input int nBits, input logic par, input logic [1:0] mode,
                          input int nStops);
        cfgDiv       = div;
        cfgBits      = nBits;
        cfgPar       = par;
        cfgStops     = nStops;
        clockDivisor = 24'(div);
        dataBits     = 2'(nBits - 5);
        hasParity    = par;
        parityMode   = mode;
        extraStopBit = (nStops == 2);
    endtask

    task automatic pushExp(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
        exp_t e;
        e.data = d; e.pe = pe; e.fe = fe; e.ov = ov;
        expQ.push_back(e);
    endtask

    task automatic idle(input int n, input logic level);
        repeat (n) begin
            @(negedge clk);
            rx = level;
            readData = 1'b0;
        end
    endtask

    // Drives one frame, one queue entry per clock. With a divisor of 0 the
    // receiver samples one clock after each bit starts, so the start bit gets
    // an extra clock there. ackAt pulses readData on that cycle; cutAt
    // asserts rst on that cycle and abandons the frame with the line idle.
    task automatic sendFrame(input logic [7:0] d, input logic parBit, input logic stopVal,
                             input int ackAt, input int cutAt);
        logic q[$];
        int   bitLen;
        bitLen = cfgDiv + 1;
        repeat (bitLen + ((cfgDiv == 0) ? 1 : 0)) q.push_back(1'b0);
        for (int k = 0; k < cfgBits; k++) repeat (bitLen) q.push_back(d[k]);
        if (cfgPar) repeat (bitLen) q.push_back(parBit);
        repeat (bitLen) q.push_back(stopVal);
        if (cfgStops == 2) repeat (bitLen) q.push_back(1'b1);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            if (i == 0) lastStart = cyc;
            if (i == cutAt) begin
                rx = 1'b1;
                readData = 1'b0;
                rst = 1'b1;
                return;
            end
            rx = q[i];
            readData = (i == ackAt);
        end
    endtask

    task automatic checkFrame(input string tag);
        exp_t e;
        total++;
        assert (expQ.size() != 0) else begin
            bad++;
            $error("FAIL %s_queue: observed=empty expected=queued frame", tag);
            return;
        end
        e = expQ.pop_front();
        check({tag, "_valid"}, 8'(dataValid), 8'd1);
        check({tag, "_data"}, dataOut, e.data);
        check({tag, "_parity"}, 8'(parityError), 8'(e.pe));
        check({tag, "_framing"}, 8'(framingError), 8'(e.fe));
        check({tag, "_overrun"}, 8'(overrun), 8'(e.ov));
    endtask

    task automatic readAndCheck(input string tag);
        logic [7:0] held;
        checkFrame(tag);
        held = dataOut;
        readData = 1'b1;
        @(negedge clk);
        readData = 1'b0;
        check({tag, "_ack_valid"}, 8'(dataValid), 8'd0);
        check({tag, "_ack_flags"}, {5'd0, parityError, framingError, overrun}, 8'd0);
        check({tag, "_ack_data_kept"}, dataOut, held);
    endtask

    initial begin
        logic pb;

        // Reset state
        setCfg(9, 8, 1'b0, 2'b00, 1);
        repeat (3) @(negedge clk);
        check("reset_data", dataOut, 8'h00);
        check("reset_valid", 8'(dataValid), 8'd0);
        check("reset_flags", {5'd0, parityError, framingError, overrun}, 8'd0);
        rst = 1'b0;
        idle(5, 1'b1);

        // 8N1 0xA5, exact completion latency and acknowledge timing
        pushExp(8'hA5, 1'b0, 1'b0, 1'b0);
        riseCyc = -1;
        sendFrame(8'hA5, 1'b0, 1'b1, -1, -1);
        idle(3, 1'b1);
        check("a5_latency", 8'(riseCyc - lastStart), 8'd98);
        checkFrame("a5");
        readData = 1'b1;
        @(negedge clk);
        readData = 1'b0;
        check("a5_ack_valid", 8'(dataValid), 8'd0);
        check("a5_ack_data_kept", dataOut, 8'hA5);
        idle(5, 1'b1);

        // 5 data bits, even parity, two stop bits: good then bad parity bit
        setCfg(9, 5, 1'b1, 2'b10, 2);
        pb = 1'b1;
        pushExp(8'h15, pb != parityFor(8'h15, 5, 2'b10), 1'b0, 1'b0);
        sendFrame(8'h15, pb, 1'b1, -1, -1);
        idle(4, 1'b1);
        readAndCheck("p5_good");
        pb = 1'b0;
        pushExp(8'h15, pb != parityFor(8'h15, 5, 2'b10), 1'b0, 1'b0);
        sendFrame(8'h15, pb, 1'b1, -1, -1);
        idle(4, 1'b1);
        readAndCheck("p5_bad");

        // Framing error, held break yields a single frame, then clean reception
        setCfg(9, 8, 1'b0, 2'b00, 1);
        pushExp(8'h3C, 1'b0, 1'b1, 1'b0);
        sendFrame(8'h3C, 1'b0, 1'b0, -1, -1);
        idle(120, 1'b0);
        readAndCheck("break");
        idle(120, 1'b0);
        check("break_no_second_frame", 8'(dataValid), 8'd0);
        idle(20, 1'b1);
        pushExp(8'h11, 1'b0, 1'b0, 1'b0);
        sendFrame(8'h11, 1'b0, 1'b1, -1, -1);
        idle(4, 1'b1);
        readAndCheck("after_break");

        // Short glitch is a false start; next frame still received
        setCfg(15, 8, 1'b0, 2'b00, 1);
        idle(5, 1'b0);
        idle(40, 1'b1);
        check("glitch_valid", 8'(dataValid), 8'd0);
        check("glitch_flags", {5'd0, parityError, framingError, overrun}, 8'd0);
        pushExp(8'h5A, 1'b0, 1'b0, 1'b0);
        sendFrame(8'h5A, 1'b0, 1'b1, -1, -1);
        idle(4, 1'b1);
        readAndCheck("after_glitch");

        // Back-to-back frames without a read: overrun
        setCfg(9, 8, 1'b0, 2'b00, 1);
        pushExp(8'h02, 1'b0, 1'b0, 1'b1);
        sendFrame(8'h01, 1'b0, 1'b1, -1, -1);
        sendFrame(8'h02, 1'b0, 1'b1, -1, -1);
        idle(4, 1'b1);
        readAndCheck("overrun");

        // Read in the completion cycle of the second frame: no overrun
        pushExp(8'h04, 1'b0, 1'b0, 1'b0);
        sendFrame(8'h03, 1'b0, 1'b1, -1, -1);
        sendFrame(8'h04, 1'b0, 1'b1, 97, -1);
        idle(4, 1'b1);
        readAndCheck("ack_at_done");

        // Divisor 0, 8O1, then a reset in the middle of a frame
        setCfg(0, 8, 1'b1, 2'b01, 1);
        pb = parityFor(8'h80, 8, 2'b01);
        pushExp(8'h80, 1'b0, 1'b0, 1'b0);
        sendFrame(8'h80, pb, 1'b1, -1, -1);
        idle(4, 1'b1);
        checkFrame("div0");
        sendFrame(8'h80, pb, 1'b1, -1, 6);
        @(negedge clk);
        check("midrst_data", dataOut, 8'h00);
        check("midrst_valid", 8'(dataValid), 8'd0);
        check("midrst_flags", {5'd0, parityError, framingError, overrun}, 8'd0);
        rst = 1'b0;
        idle(5, 1'b1);
        pushExp(8'h80, 1'b0, 1'b0, 1'b0);
        sendFrame(8'h80, pb, 1'b1, -1, -1);
        idle(4, 1'b1);
        readAndCheck("div0_after_rst");

        check("scoreboard_drained", 8'(expQ.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
